// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, memory and status signals of mem_arbiter (stats ports under MEM_ARB_STATS_EN)
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic [ADDR_WIDTH-1:0] mem_read_address;
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_write_address;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;

    logic                  last_owner;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]           conflict_count;
    logic [15:0]           starve_events;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_data_out,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_read_address, mem_write_enable, mem_write_address, mem_data_in,
        output last_owner, conflict_count, starve_events
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_data_out,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_read_address, mem_write_enable, mem_write_address, mem_data_in,
        input  last_owner, conflict_count, starve_events
    );
`else
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_data_out,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_read_address, mem_write_enable, mem_write_address, mem_data_in,
        output last_owner
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_data_out,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_read_address, mem_write_enable, mem_write_address, mem_data_in,
        input  last_owner
    );
`endif
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master fixed-priority memory arbiter with m1 anti-starvation slot
// Optional cycle statistics enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic                  m0_gnt;
    logic                  m1_gnt;
    logic                  forced;
    logic                  any_gnt;
    logic                  rd_gnt;
    logic                  wr_gnt;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic [7:0]            starve_cnt_q, starve_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  tag_valid_q, tag_valid_d;
    logic                  tag_owner_q, tag_owner_d;
    logic                  last_owner_q, last_owner_d;

    // m0 wins every tie except when m1 has been denied STARVE_LIMIT cycles in a row
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        forced = 1'b0;
        if (!reset) begin
            if (bus.m0_req && bus.m1_req) begin
                forced = (starve_cnt_q == LIMIT);
                m1_gnt = forced;
                m0_gnt = !forced;
            end else begin
                m0_gnt = bus.m0_req;
                m1_gnt = bus.m1_req;
            end
        end
    end

    assign any_gnt   = m0_gnt | m1_gnt;
    assign sel_we    = m1_gnt ? bus.m1_we    : bus.m0_we;
    assign sel_addr  = m1_gnt ? bus.m1_addr  : bus.m0_addr;
    assign sel_wdata = m1_gnt ? bus.m1_wdata : bus.m0_wdata;
    assign wr_gnt    = any_gnt & sel_we;
    assign rd_gnt    = any_gnt & ~sel_we;

    always_comb begin
        starve_cnt_d = 8'd0;
        if (bus.m1_req && !m1_gnt) begin
            starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 8'd1;
        end
    end

    // Memory pins show the granted request, otherwise hold the last driven values
    assign rd_addr_d    = rd_gnt ? sel_addr  : rd_addr_q;
    assign wr_addr_d    = wr_gnt ? sel_addr  : wr_addr_q;
    assign wr_data_d    = wr_gnt ? sel_wdata : wr_data_q;
    assign tag_valid_d  = rd_gnt;
    assign tag_owner_d  = m1_gnt;
    assign last_owner_d = any_gnt ? m1_gnt : last_owner_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q <= 8'd0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            tag_valid_q  <= 1'b0;
            tag_owner_q  <= 1'b0;
            last_owner_q <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            tag_valid_q  <= tag_valid_d;
            tag_owner_q  <= tag_owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign bus.m0_gnt            = m0_gnt;
    assign bus.m1_gnt            = m1_gnt;
    assign bus.mem_read_address  = rd_addr_d;
    assign bus.mem_write_enable  = wr_gnt;
    assign bus.mem_write_address = wr_addr_d;
    assign bus.mem_data_in       = wr_data_d;
    // A read return that lands while reset is high is dropped
    assign bus.m0_rvalid         = tag_valid_q & ~tag_owner_q & ~reset;
    assign bus.m1_rvalid         = tag_valid_q &  tag_owner_q & ~reset;
    assign bus.m0_rdata          = bus.mem_data_out;
    assign bus.m1_rdata          = bus.mem_data_out;
    assign bus.last_owner        = last_owner_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_q, conflict_d;
    logic [15:0] starve_ev_q, starve_ev_d;

    assign conflict_d  = (bus.m0_req && bus.m1_req) ? conflict_q + 16'd1 : conflict_q;
    assign starve_ev_d = forced ? starve_ev_q + 16'd1 : starve_ev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_q  <= 16'd0;
            starve_ev_q <= 16'd0;
        end else begin
            conflict_q  <= conflict_d;
            starve_ev_q <= starve_ev_d;
        end
    end

    assign bus.conflict_count = conflict_q;
    assign bus.starve_events  = starve_ev_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter with a behavioural memory_block
module tb_mem_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem [0:1023];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ 16'h5A00;
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0001] = 16'h1111;
        mem[16'h0002] = 16'h2222;
        mem[16'h0003] = 16'h3333;
    end

    always @(posedge clock) begin
        if (bus.mem_write_enable) mem[bus.mem_write_address[9:0]] <= bus.mem_data_in;
        bus.mem_data_out <= mem[bus.mem_read_address[9:0]];
    end

    typedef struct {
        string       name;
        int          op0;
        logic [15:0] a0;
        logic [15:0] d0;
        int          op1;
        logic [15:0] a1;
        logic [15:0] d1;
        logic        e_g0;
        logic        e_g1;
        logic        e_mwe;
        logic        e_rv0;
        logic        e_rv1;
        logic [15:0] e_rdata;
        logic        e_lo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, int op0, logic [15:0] a0, logic [15:0] d0,
                                int op1, logic [15:0] a1, logic [15:0] d1,
                                logic g0, logic g1, logic mwe, logic rv0, logic rv1,
                                logic [15:0] rd, logic lo);
        vec_t v;
        v.name = nm; v.op0 = op0; v.a0 = a0; v.d0 = d0; v.op1 = op1; v.a1 = a1; v.d1 = d1;
        v.e_g0 = g0; v.e_g1 = g1; v.e_mwe = mwe; v.e_rv0 = rv0; v.e_rv1 = rv1;
        v.e_rdata = rd; v.e_lo = lo;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apply(int op0, logic [15:0] a0, logic [15:0] d0,
                         int op1, logic [15:0] a1, logic [15:0] d1);
        bus.m0_req = (op0 != 0); bus.m0_we = (op0 == 2); bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = (op1 != 0); bus.m1_we = (op1 == 2); bus.m1_addr = a1; bus.m1_wdata = d1;
    endtask

    task automatic check_vec(vec_t v);
        chk({v.name, ".m0_gnt"}, 32'(bus.m0_gnt), 32'(v.e_g0));
        chk({v.name, ".m1_gnt"}, 32'(bus.m1_gnt), 32'(v.e_g1));
        chk({v.name, ".mwe"}, 32'(bus.mem_write_enable), 32'(v.e_mwe));
        chk({v.name, ".m0_rvalid"}, 32'(bus.m0_rvalid), 32'(v.e_rv0));
        chk({v.name, ".m1_rvalid"}, 32'(bus.m1_rvalid), 32'(v.e_rv1));
        chk({v.name, ".last_owner"}, 32'(bus.last_owner), 32'(v.e_lo));
        if (v.e_rv0) chk({v.name, ".m0_rdata"}, 32'(bus.m0_rdata), 32'(v.e_rdata));
        if (v.e_rv1) chk({v.name, ".m1_rdata"}, 32'(bus.m1_rdata), 32'(v.e_rdata));
        if (v.e_mwe) begin
            chk({v.name, ".waddr"}, 32'(bus.mem_write_address), 32'(v.e_g1 ? v.a1 : v.a0));
            chk({v.name, ".wdata"}, 32'(bus.mem_data_in), 32'(v.e_g1 ? v.d1 : v.d0));
        end
    endtask

    initial begin
        // op: 0 idle, 1 read, 2 write
        vecs.push_back(mk("solo_rd0",  1, 16'h0010, 0, 0, 0, 0,               1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("solo_ret0", 0, 0, 0, 0, 0, 0,                      0, 0, 0, 1, 0, 16'hBEEF, 0));
        vecs.push_back(mk("m1_wr",     0, 0, 0, 2, 16'h0200, 16'h1234,        0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("m1_rd",     0, 0, 0, 1, 16'h0200, 0,              0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("m1_ret",    0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 1, 16'h1234, 1));
        vecs.push_back(mk("il_m0a",    1, 16'h0001, 0, 0, 0, 0,               1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("il_m1b",    0, 0, 0, 1, 16'h0002, 0,               0, 1, 0, 1, 0, 16'h1111, 0));
        vecs.push_back(mk("il_m0c",    1, 16'h0003, 0, 0, 0, 0,               1, 0, 0, 0, 1, 16'h2222, 1));
        vecs.push_back(mk("il_ret",    0, 0, 0, 0, 0, 0,                      0, 0, 0, 1, 0, 16'h3333, 0));
        // ten cycles of contention: four m0 grants then a forced m1 grant, twice
        for (int k = 0; k < 10; k++) begin
            logic win1;
            logic rv0;
            logic rv1;
            logic lo;
            win1 = (k == 4) || (k == 9);
            rv0  = (k != 0) && (k != 5);
            rv1  = (k == 5);
            lo   = (k == 5);
            vecs.push_back(mk($sformatf("cont%0d", k), 1, 16'h0010, 0, 1, 16'h0200, 0,
                              !win1, win1, 0, rv0, rv1, rv1 ? 16'h1234 : 16'hBEEF, lo));
        end
        vecs.push_back(mk("cont_ret",  0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 1, 16'h1234, 1));
        // m1 denied three cycles, drops one, then needs four more denials
        for (int k = 0; k < 9; k++) begin
            logic m1r;
            logic win1;
            m1r  = (k != 3);
            win1 = (k == 8);
            vecs.push_back(mk($sformatf("drop%0d", k), 1, 16'h0010, 0, m1r ? 1 : 0, 16'h0200, 0,
                              !win1, win1, 0, k != 0, 0, 16'hBEEF, k == 0));
        end
        vecs.push_back(mk("drop_ret",  0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 1, 16'h1234, 1));

        apply(0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1 apply(1, 16'h0010, 0, 1, 16'h0200, 0);
        @(negedge clock);
        chk("rst.m0_gnt", 32'(bus.m0_gnt), 0);
        chk("rst.m1_gnt", 32'(bus.m1_gnt), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        apply(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("rst.last_owner", 32'(bus.last_owner), 0);
        chk("rst.rvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 0);
        chk("rst.mwe", 32'(bus.mem_write_enable), 0);
        chk("rst.raddr", 32'(bus.mem_read_address), 0);
        chk("rst.waddr", 32'(bus.mem_write_address), 0);
        chk("rst.wdata", 32'(bus.mem_data_in), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clock);
            #1 apply(vecs[i].op0, vecs[i].a0, vecs[i].d0, vecs[i].op1, vecs[i].a1, vecs[i].d1);
            @(negedge clock);
            check_vec(vecs[i]);
`ifdef MEM_ARB_STATS_EN
            if (vecs[i].name == "cont_ret") begin
                chk("stats.conflict", 32'(bus.conflict_count), 10);
                chk("stats.starve", 32'(bus.starve_events), 2);
            end
`endif
        end

        // reset lands on the return edge of an m0 read, with m1 partly starved
        @(posedge clock);
        #1 apply(1, 16'h0010, 0, 1, 16'h0200, 0);
        @(negedge clock);
        chk("mid.g0_a", 32'(bus.m0_gnt), 1);
        @(posedge clock);
        #1 apply(1, 16'h0010, 0, 1, 16'h0200, 0);
        @(negedge clock);
        chk("mid.g0_b", 32'(bus.m0_gnt), 1);
        @(posedge clock);
        #1 reset = 1'b1;
        apply(2, 16'h0040, 16'hAAAA, 1, 16'h0200, 0);
        @(negedge clock);
        chk("mid.m0_rvalid", 32'(bus.m0_rvalid), 0);
        chk("mid.gnt", 32'({bus.m0_gnt, bus.m1_gnt}), 0);
        chk("mid.mwe", 32'(bus.mem_write_enable), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        apply(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("post.rvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 0);
        chk("post.last_owner", 32'(bus.last_owner), 0);
        chk("post.raddr", 32'(bus.mem_read_address), 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1 apply(1, 16'h0010, 0, 1, 16'h0200, 0);
            @(negedge clock);
            chk($sformatf("post.g0_%0d", k), 32'(bus.m0_gnt), 32'(k != 4));
            chk($sformatf("post.g1_%0d", k), 32'(bus.m1_gnt), 32'(k == 4));
`ifdef MEM_ARB_STATS_EN
            if (k == 4) chk("post.conflict", 32'(bus.conflict_count), 4);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single `memory_block` port between two requesters:
  - m0: the CPU fetch/load/store path.
  - m1: a secondary master, e.g. a UART program loader or DMA engine.
- Fixed priority to m0. m1 gets a guaranteed anti-starvation slot.
- Sits between both masters and `memory_block`, drives its read/write address, enable and data pins, and returns read data with the memory's 1-cycle read latency.

Parameters:
- ADDR_WIDTH, 16, address width of both masters and memory.
- DATA_WIDTH, 16, data word width.
- STARVE_LIMIT, 4, number of consecutive denied m1 request cycles before m1 is forced to win. Legal range 1..255.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  m0 access request, valid this cycle.
- m0_we  input  1  1 = write, 0 = read.
- m0_addr  input  ADDR_WIDTH  m0 word address.
- m0_wdata  input  DATA_WIDTH  m0 write data.
- m0_gnt  output  1  m0 access accepted this cycle (combinational).
- m0_rvalid  output  1  m0 read data valid (1 cycle after read grant).
- m0_rdata  output  DATA_WIDTH  read data to m0.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for m1.
- mem_read_address  output  ADDR_WIDTH  to memory_block read_address.
- mem_write_enable  output  1  to memory_block write_enable.
- mem_write_address  output  ADDR_WIDTH  to memory_block write_address.
- mem_data_in  output  DATA_WIDTH  to memory_block data_in.
- mem_data_out  input  DATA_WIDTH  from memory_block data_out. Registered read: valid 1 cycle after address.
- last_owner  output  1  registered; master granted in the most recent granted cycle.

Behaviour:
- **Grant (combinational, same cycle)**
  - reset=1: both gnt=0.
  - Only one req: that master is granted.
  - Both req: m1 wins iff starve_cnt == STARVE_LIMIT; otherwise m0 wins.
  - At most one gnt is high in any cycle.
- **Starvation counter** (8-bit, registered)
  - Increments when m1_req & ~m1_gnt, saturating at STARVE_LIMIT.
  - Clears to 0 when m1_gnt or ~m1_req.
- **Memory drive**
  - Granted write: mem_write_enable=1, mem_write_address=addr, mem_data_in=wdata. No rvalid is generated.
  - Granted read: mem_read_address=addr, mem_write_enable=0.
  - No grant: mem_write_enable=0. mem_read_address, mem_write_address and mem_data_in hold their last driven values (registered hold mux).
- **Read return**
  - A registered tag {valid, owner} is captured on each read grant.
  - Next cycle, the tagged master's rvalid=1 for exactly one cycle.
  - Both m0_rdata and m1_rdata = mem_data_out directly; consumers qualify with rvalid.
- **Back-to-back reads**
  - One read may issue every cycle.
  - Reads alternating between masters return in issue order, one per cycle.
- **Read-after-write, same address, consecutive cycles:** the read returns the new data (memory write-first not required; the arbiter does no forwarding, so this relies on memory_block ordering).
- **Reset values** (synchronous; takes effect on the edge with reset=1):
  - starve_cnt=0, tag valid=0, last_owner=0.
  - held mem_read_address, mem_write_address and mem_data_in = 0.
  - all rvalid=0, mem_write_enable=0.
- **Reset mid-operation:** a read granted the cycle before reset produces no rvalid if reset is high on the return edge. Requests during reset are not granted and are not queued.
- Requests are not latched. A denied master must hold req/addr/we/wdata until it sees gnt.

Optional Feature:
- Macro: `MEM_ARB_STATS_EN`.
- Defined:
  - Adds output port conflict_count (16 bits), counting cycles with m0_req & m1_req. Wraps 0xFFFF→0.
  - Adds output port starve_events (16 bits), counting forced m1 wins. Wraps.
  - Both clear on reset.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- **Solo m0 read:** m0 read addr 0x0010 (mem holds 0xBEEF) → m0_gnt same cycle; next cycle m0_rvalid=1, m0_rdata=0xBEEF; m1_rvalid=0.
- **Write then read, m1 alone:** write 0x1234 to 0x0200, then read 0x0200 → mem_write_enable pulses 1 cycle with the correct addr/data; read returns 0x1234 with m1_rvalid the cycle after the read grant.
- **Contention, STARVE_LIMIT=4:** both hold read req continuously → m0 granted 4 cycles, m1 granted on the 5th, pattern repeats; no cycle with both gnt=1. With stats enabled: conflict_count=10 and starve_events=2 after 10 cycles.
- **Interleaved reads:** m0 @0x0001, then m1 @0x0002, then m0 @0x0003 on consecutive cycles → rvalid to m0, m1, m0 on the following cycles with the matching data.
- **Reset mid-read:** m0 read granted; reset=1 on the next edge → m0_rvalid stays 0, starve_cnt=0, mem_write_enable=0 during reset, no gnt while reset=1.
- **m1 drops req:** m1 denied 3 cycles, deasserts 1 cycle, reasserts → starve_cnt restarts from 0; m1 is forced only after 4 further denied cycles.
